// File: rtl/ase_quiesce_monitor.sv
// ase_quiesce_monitor: protocol-independent in-flight transaction tracker.
// Counts outstanding reads and writes, reports a registered idle level after a
// run of quiet cycles, and answers a drain (lockdown) request once traffic has
// retired. One instance per simulated AFU port.
module ase_quiesce_monitor #(
    parameter int MAX_OUTSTANDING  = 512,
    parameter int IDLE_HOLD_CYCLES = 16,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             SoftReset,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic             rd_rsp_valid,
    input  logic             wr_req_valid,
    output logic             wr_req_ready,
    input  logic             wr_rsp_valid,
    input  logic             drain_req,
    output logic             drain_ack,
    output logic             system_is_idle,
    output logic [CNT_W-1:0] rd_outstanding,
    output logic [CNT_W-1:0] wr_outstanding,
    output logic             err_underflow,
    output logic             err_overflow
);

    localparam int IDLE_W = $clog2(IDLE_HOLD_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_HOLD_CYCLES);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_DRAINED = 2'd2;

    logic [1:0]        state_q,    state_d;
    logic [CNT_W-1:0]  rd_cnt_q,   rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q,   wr_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              idle_q,     idle_d;
    logic              ack_q,      ack_d;
    logic              uf_q,       uf_d;
    logic              of_q,       of_d;

    logic rd_acc;
    logic wr_acc;
    logic quiet;

    // A response with nothing outstanding (and no accept to pair with) is
    // dropped: the count holds at zero and the underflow flag records it.
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cnt,
                                                    input logic             acc,
                                                    input logic             rsp);
        if (acc && !rsp) begin
            return cnt + CNT_W'(1);
        end else if (rsp && !acc && (cnt != '0)) begin
            return cnt - CNT_W'(1);
        end
        return cnt;
    endfunction

    // Admission is only possible in RUN, below the limit and outside reset.
    assign rd_req_ready = !SoftReset && (state_q == ST_RUN) && (rd_cnt_q < CNT_MAX);
    assign wr_req_ready = !SoftReset && (state_q == ST_RUN) && (wr_cnt_q < CNT_MAX);

    assign rd_acc = rd_req_valid && rd_req_ready;
    assign wr_acc = wr_req_valid && wr_req_ready;

    assign quiet = (rd_cnt_q == '0) && (wr_cnt_q == '0) && !rd_acc && !wr_acc &&
                   !rd_rsp_valid && !wr_rsp_valid;

    // Next-state for counters, idle tracking, error flags and drain FSM.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can
        // leave it unassigned and infer a latch.
        state_d    = state_q;
        rd_cnt_d   = next_count(rd_cnt_q, rd_acc, rd_rsp_valid);
        wr_cnt_d   = next_count(wr_cnt_q, wr_acc, wr_rsp_valid);
        idle_cnt_d = '0;
        idle_d     = 1'b0;
        uf_d       = uf_q;
        of_d       = of_q;

        if ((rd_rsp_valid && !rd_acc && (rd_cnt_q == '0)) ||
            (wr_rsp_valid && !wr_acc && (wr_cnt_q == '0))) begin
            uf_d = 1'b1;
        end

        if ((state_q == ST_RUN) &&
            ((rd_req_valid && (rd_cnt_q == CNT_MAX)) ||
             (wr_req_valid && (wr_cnt_q == CNT_MAX)))) begin
            of_d = 1'b1;
        end

        // Idle rises on the edge that closes the IDLE_HOLD_CYCLES-th quiet cycle.
        if (quiet) begin
            idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IDLE_W'(1);
            idle_d     = (idle_cnt_q >= IDLE_MAX - IDLE_W'(1));
        end

        case (state_q)
            ST_RUN: begin
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)   state_d = ST_RUN;
                else if (idle_q)  state_d = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        ack_d = (state_d == ST_DRAINED);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (SoftReset) begin
            state_q    <= ST_RUN;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            idle_cnt_q <= '0;
            idle_q     <= 1'b0;
            ack_q      <= 1'b0;
            uf_q       <= 1'b0;
            of_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
            ack_q      <= ack_d;
            uf_q       <= uf_d;
            of_q       <= of_d;
        end
    end

    assign drain_ack      = ack_q;
    assign system_is_idle = idle_q;
    assign rd_outstanding = rd_cnt_q;
    assign wr_outstanding = wr_cnt_q;
    assign err_underflow  = uf_q;
    assign err_overflow   = of_q;

endmodule

// File: tb/tb_ase_quiesce_monitor.sv
// Self-checking bench for ase_quiesce_monitor: a cycle-level behavioural model
// compared against the DUT every cycle, plus directed literal expectations.
module tb_ase_quiesce_monitor;

    localparam int MAX  = 6;
    localparam int HOLD = 16;
    localparam int CW   = $clog2(MAX + 1);

    logic          clk = 1'b0;
    logic          SoftReset;
    logic          rd_req_valid, rd_rsp_valid, wr_req_valid, wr_rsp_valid;
    logic          drain_req;
    logic          rd_req_ready, wr_req_ready, drain_ack, system_is_idle;
    logic [CW-1:0] rd_outstanding, wr_outstanding;
    logic          err_underflow, err_overflow;

    always #5 clk = ~clk;

    ase_quiesce_monitor #(
        .MAX_OUTSTANDING (MAX),
        .IDLE_HOLD_CYCLES(HOLD)
    ) dut (
        .clk           (clk),
        .SoftReset     (SoftReset),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_rsp_valid  (rd_rsp_valid),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_rsp_valid  (wr_rsp_valid),
        .drain_req     (drain_req),
        .drain_ack     (drain_ack),
        .system_is_idle(system_is_idle),
        .rd_outstanding(rd_outstanding),
        .wr_outstanding(wr_outstanding),
        .err_underflow (err_underflow),
        .err_overflow  (err_overflow)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {P_RUN, P_DRAIN, P_DONE} phase_t;
    phase_t m_phase;
    int     m_rd, m_wr, m_streak;
    bit     m_idle, m_uf, m_of;
    bit     m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit ra, wa, quiet;
        if (SoftReset) begin
            m_phase  = P_RUN;
            m_rd     = 0;
            m_wr     = 0;
            m_streak = 0;
            m_idle   = 0;
            m_uf     = 0;
            m_of     = 0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            ra = rd_req_valid && m_phase == P_RUN && m_rd < MAX;
            wa = wr_req_valid && m_phase == P_RUN && m_wr < MAX;
            if (m_phase == P_RUN && ((rd_req_valid && m_rd == MAX) || (wr_req_valid && m_wr == MAX)))
                m_of = 1;
            quiet = m_rd == 0 && m_wr == 0 && !ra && !wa && !rd_rsp_valid && !wr_rsp_valid;
            if (rd_rsp_valid && !ra && m_rd == 0) m_uf = 1;
            else m_rd = m_rd + int'(ra) - int'(rd_rsp_valid);
            if (wr_rsp_valid && !wa && m_wr == 0) m_uf = 1;
            else m_wr = m_wr + int'(wa) - int'(wr_rsp_valid);
            m_streak = quiet ? m_streak + 1 : 0;
            case (m_phase)
                P_RUN:   if (drain_req) m_phase = P_DRAIN;
                P_DRAIN: if (!drain_req) m_phase = P_RUN; else if (m_idle) m_phase = P_DONE;
                P_DONE:  if (!drain_req) m_phase = P_RUN;
                default: m_phase = P_RUN;
            endcase
            m_idle = m_streak >= HOLD;
        end
    end

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("m_rd_outstanding", rd_outstanding, m_rd);
            check("m_wr_outstanding", wr_outstanding, m_wr);
            check("m_rd_ready", rd_req_ready, !SoftReset && m_phase == P_RUN && m_rd < MAX);
            check("m_wr_ready", wr_req_ready, !SoftReset && m_phase == P_RUN && m_wr < MAX);
            check("m_idle", system_is_idle, m_idle);
            check("m_drain_ack", drain_ack, m_phase == P_DONE);
            check("m_err_underflow", err_underflow, m_uf);
            check("m_err_overflow", err_overflow, m_of);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int n;
        SoftReset    = 1'b1;
        rd_req_valid = 1'b0;
        rd_rsp_valid = 1'b0;
        wr_req_valid = 1'b0;
        wr_rsp_valid = 1'b0;
        drain_req    = 1'b0;
        step(3);
        check("rst_rd_ready", rd_req_ready, 0);
        check("rst_wr_ready", wr_req_ready, 0);
        check("rst_idle", system_is_idle, 0);
        check("rst_rd_cnt", rd_outstanding, 0);
        check("rst_ack", drain_ack, 0);

        // Reset release: idle after exactly HOLD quiet cycles.
        SoftReset = 1'b0;
        #1;
        check("rel_rd_ready", rd_req_ready, 1);
        check("rel_wr_ready", wr_req_ready, 1);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check($sformatf("rel_idle_c%0d", k), system_is_idle, k >= 16);
        end
        step(2);

        // Three reads in, three out.
        rd_req_valid = 1'b1;
        step(1); check("rd_cnt_1", rd_outstanding, 1); check("idle_fall", system_is_idle, 0);
        step(1); check("rd_cnt_2", rd_outstanding, 2);
        step(1); check("rd_cnt_3", rd_outstanding, 3);
        rd_req_valid = 1'b0;
        rd_rsp_valid = 1'b1;
        step(1); check("rd_cnt_2b", rd_outstanding, 2);
        step(1); check("rd_cnt_1b", rd_outstanding, 1);
        step(1); check("rd_cnt_0", rd_outstanding, 0);
        rd_rsp_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check($sformatf("re_idle_c%0d", k), system_is_idle, k == 16);
        end
        check("rd_no_uf", err_underflow, 0);
        check("rd_no_of", err_overflow, 0);

        // Same-cycle accept and response at count 5.
        rd_req_valid = 1'b1;
        step(5);
        check("rd_cnt_5", rd_outstanding, 5);
        rd_rsp_valid = 1'b1;
        step(1);
        check("rd_same_cycle", rd_outstanding, 5);
        check("rd_same_idle", system_is_idle, 0);
        rd_req_valid = 1'b0;
        step(5);
        rd_rsp_valid = 1'b0;
        check("rd_drained_0", rd_outstanding, 0);
        check("rd_same_no_uf", err_underflow, 0);

        // Write overflow: MAX+1 consecutive valids.
        wr_req_valid = 1'b1;
        for (int k = 1; k <= MAX + 1; k++) begin
            check($sformatf("wr_ready_k%0d", k), wr_req_ready, k <= MAX);
            step(1);
        end
        wr_req_valid = 1'b0;
        check("wr_cnt_max", wr_outstanding, MAX);
        check("wr_overflow", err_overflow, 1);
        wr_rsp_valid = 1'b1;
        step(MAX);
        wr_rsp_valid = 1'b0;
        check("wr_cnt_0", wr_outstanding, 0);
        check("wr_no_uf", err_underflow, 0);

        // Drain with two reads outstanding.
        rd_req_valid = 1'b1;
        step(2);
        rd_req_valid = 1'b0;
        check("dr_rd_2", rd_outstanding, 2);
        drain_req = 1'b1;
        step(1);
        check("dr_rd_ready0", rd_req_ready, 0);
        check("dr_wr_ready0", wr_req_ready, 0);
        rd_rsp_valid = 1'b1;
        step(2);
        rd_rsp_valid = 1'b0;
        check("dr_rd_0", rd_outstanding, 0);
        n = 0;
        while (drain_ack !== 1'b1 && n < 40) begin
            step(1);
            n++;
        end
        check("dr_ack_latency", n, HOLD + 1);
        check("dr_ack_high", drain_ack, 1);
        drain_req = 1'b0;
        step(1);
        check("dr_ack_low", drain_ack, 0);
        check("dr_ready_back", rd_req_ready, 1);

        // Mid-operation reset, then a stale response underflows.
        rd_req_valid = 1'b1;
        step(1);
        rd_req_valid = 1'b0;
        check("mr_rd_1", rd_outstanding, 1);
        SoftReset = 1'b1;
        step(1);
        check("mr_rd_0", rd_outstanding, 0);
        check("mr_of_clear", err_overflow, 0);
        check("mr_idle_0", system_is_idle, 0);
        SoftReset = 1'b0;
        rd_rsp_valid = 1'b1;
        step(1);
        rd_rsp_valid = 1'b0;
        check("uf_set", err_underflow, 1);
        check("uf_cnt_0", rd_outstanding, 0);
        step(3);
        check("uf_sticky", err_underflow, 1);
        SoftReset = 1'b1;
        step(1);
        SoftReset = 1'b0;
        check("uf_cleared", err_underflow, 0);

        // Drain aborted while traffic is outstanding.
        rd_req_valid = 1'b1;
        step(1);
        rd_req_valid = 1'b0;
        drain_req = 1'b1;
        step(1);
        check("ab_ready0", rd_req_ready, 0);
        step(4);
        check("ab_no_ack", drain_ack, 0);
        drain_req = 1'b0;
        step(1);
        check("ab_ready1", rd_req_ready, 1);
        check("ab_ack0", drain_ack, 0);
        rd_rsp_valid = 1'b1;
        step(1);
        rd_rsp_valid = 1'b0;
        check("ab_rd_0", rd_outstanding, 0);
        step(20);
        check("ab_idle", system_is_idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
